// File: rtl/dcache_stb_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_defs (package)
//  Description : Shared store-buffer <-> dcache types, widths and FSM states.
//  Revision    : 1.0
// ============================================================================
package cache_defs;

   localparam int DCACHE_ADDR_WIDTH = 32;
   localparam int DCACHE_DATA_WIDTH = 32;

   typedef struct packed {
      logic [DCACHE_ADDR_WIDTH-1:0] addr;
      logic [DCACHE_DATA_WIDTH-1:0] w_data;
      logic [3:0]                   sel_byte;
      logic                         w_en;
      logic                         req;
   } type_stb2dcache_s;

   typedef struct packed {
      logic                         ack;
      logic [DCACHE_DATA_WIDTH-1:0] r_data;
   } type_dcache2stb_s;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } type_stb_state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_stb_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_stb_responder_if
//  Description : Request/response bundle between the store buffer and dcache.
//  Revision    : 1.0
// ============================================================================
interface dcache_stb_responder_if;
   import cache_defs::*;

   type_stb2dcache_s stb2dcache_i;
   logic             dmem_sel_i;
   type_dcache2stb_s dcache2stb_o;
   logic             busy_o;
   logic [15:0]      wr_count_o;

   modport master (
      output stb2dcache_i,
      output dmem_sel_i,
      input  dcache2stb_o,
      input  busy_o,
      input  wr_count_o
   );

   modport slave (
      input  stb2dcache_i,
      input  dmem_sel_i,
      output dcache2stb_o,
      output busy_o,
      output wr_count_o
   );

endinterface
`default_nettype wire

// File: rtl/dcache_stb_resp_mem.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_stb_resp_mem
//  Description : Byte-enabled word array, synchronous write, asynchronous read.
//  Revision    : 1.0
// ============================================================================
module dcache_stb_resp_mem
   import cache_defs::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  wire logic                         clk,
   input  wire logic                         i_we,
   input  wire logic [IDX_W-1:0]             i_addr,
   input  wire logic [DCACHE_DATA_WIDTH-1:0] i_wdata,
   input  wire logic [3:0]                   i_be,
   output logic      [DCACHE_DATA_WIDTH-1:0] o_rdata
);

   // Contents are deliberately never reset.
   logic [DCACHE_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dcache_stb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_stb_responder
//  Description : Single-outstanding dcache responder with fixed ack latency.
//  Revision    : 1.0
// ============================================================================
module dcache_stb_responder
   import cache_defs::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int LATENCY   = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   dcache_stb_responder_if.slave bus
);

   localparam int         c_IDX_W   = $clog2(MEM_DEPTH);
   localparam logic [3:0] c_LATENCY = 4'(LATENCY);

   type_stb_state_e              r_state;
   type_stb_state_e              w_state_nxt;
   logic [3:0]                   r_cnt;
   logic [3:0]                   w_cnt_nxt;
   logic [c_IDX_W-1:0]           r_idx;
   logic [DCACHE_DATA_WIDTH-1:0] r_wdata;
   logic [3:0]                   r_sel;
   logic                         r_wen;
   logic [15:0]                  r_wr_count;
   logic                         w_capture;
   logic                         w_access;
   logic                         w_mem_we;
   logic                         w_ack;
   logic [DCACHE_DATA_WIDTH-1:0] w_mem_rdata;
   type_dcache2stb_s             w_resp;
   logic                         w_unused_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.stb2dcache_i.req && bus.dmem_sel_i) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = c_LATENCY;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_access    = 1'b1;
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_wr_count <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_access && r_wen && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
         if (w_capture) begin
            r_idx   <= bus.stb2dcache_i.addr[c_IDX_W+1:2];
            r_wdata <= bus.stb2dcache_i.w_data;
            r_sel   <= bus.stb2dcache_i.sel_byte;
            r_wen   <= bus.stb2dcache_i.w_en;
         end
      end
   end

   // A reset landing on the access edge must not commit the write.
   assign w_mem_we = w_access && r_wen && !rst;

   dcache_stb_resp_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (c_IDX_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_addr  (r_idx),
      .i_wdata (r_wdata),
      .i_be    (r_sel),
      .o_rdata (w_mem_rdata)
   );

   // Write lands on the RESP entry edge, so RESP reads the post-merge word.
   assign w_ack = (r_state == ST_RESP);

   always_comb begin
      w_resp        = '0;
      w_resp.ack    = w_ack;
      w_resp.r_data = w_ack ? w_mem_rdata : '0;
   end

   assign bus.dcache2stb_o = w_resp;
   assign bus.busy_o       = (r_state != ST_IDLE);
   assign bus.wr_count_o   = r_wr_count;

   assign w_unused_addr = ^{bus.stb2dcache_i.addr[DCACHE_ADDR_WIDTH-1:c_IDX_W+2],
                            bus.stb2dcache_i.addr[1:0]};

endmodule
`default_nettype wire
